// File: rtl/pipe_pkg.sv
// Pipeline-wide constants and the IF/ID register payload shared by fetch and decode.
package pipe_pkg;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned IMEM_ADDR_W = 11;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
    if_id_t b;
    b.pc    = '0;
    b.instr = nop;
    b.valid = 1'b0;
    return b;
  endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface if_fetch_stage_if #(
  parameter int unsigned IMEM_ADDR_W = pipe_pkg::IMEM_ADDR_W
);
  logic                   stall;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_rdata;
  logic [31:0]            if_id_pc;
  logic [31:0]            if_id_instr;
  logic                   if_id_valid;
  logic [31:0]            fetch_cnt;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_cnt
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid, fetch_cnt
  );
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, otherwise loads when enabled.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  pipe_pkg::if_id_t d,
  output pipe_pkg::if_id_t q
);
  import pipe_pkg::*;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= if_id_bubble(NOP_INSTR);
    end else if (flush) begin
      q <= if_id_bubble(NOP_INSTR);
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, imem addressing, IF/ID latch and fetch counter.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = pipe_pkg::RESET_PC,
  parameter int unsigned IMEM_ADDR_W = pipe_pkg::IMEM_ADDR_W,
  parameter logic [31:0] NOP_INSTR   = pipe_pkg::NOP_INSTR
) (
  input logic               clk,
  input logic               rst_n,
  if_fetch_stage_if.master  bus
);
  import pipe_pkg::*;

  logic [31:0] pc;
  logic        advance;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  // Redirect outranks stall, so only a quiet cycle moves the PC forward.
  assign advance = !bus.redirect && !bus.stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      bus.fetch_cnt <= '0;
    end else if (bus.redirect) begin
      pc <= bus.redirect_pc & ~32'h0000_0003;
    end else if (advance) begin
      pc            <= pc + 32'd4;
      bus.fetch_cnt <= bus.fetch_cnt + 32'd1;
    end
  end

  // Address depends on pc alone; high bits alias into the 2 KB memory.
  assign bus.imem_addr = pc[IMEM_ADDR_W-1:0];

  always_comb begin
    if_id_d       = '0;
    if_id_d.pc    = pc;
    if_id_d.instr = bus.imem_rdata;
    if_id_d.valid = 1'b1;
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!bus.stall),
    .flush (bus.redirect),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign bus.if_id_pc    = if_id_q.pc;
  assign bus.if_id_instr = if_id_q.instr;
  assign bus.if_id_valid = if_id_q.valid;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed and randomized checks of if_fetch_stage against an abstract fetch model.
module tb_if_fetch_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  if_fetch_stage_if #(.IMEM_ADDR_W(11)) bus ();

  if_fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_ADDR_W (11),
    .NOP_INSTR   (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [512];
  assign bus.imem_rdata = mem[bus.imem_addr[10:2]];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_ifpc, m_instr, m_cnt;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_model();
    chk("imem_addr", {21'd0, bus.imem_addr}, {21'd0, m_pc[10:0]});
    chk("if_id_pc", bus.if_id_pc, m_ifpc);
    chk("if_id_instr", bus.if_id_instr, m_instr);
    chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
    chk("fetch_cnt", bus.fetch_cnt, m_cnt);
  endtask

  // One clock: apply inputs, advance the model by the fetch rules, then compare.
  task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    rst_n           = r;
    bus.stall       = s;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    @(posedge clk);
    if (!r) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_instr = 32'h13; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (rd) begin
      m_pc = rpc & ~32'h3; m_ifpc = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
    end else if (!s) begin
      m_ifpc  = m_pc;
      m_instr = mem[m_pc[10:2]];
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    #1;
    cmp_model();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[0] = 32'hA000_000A;
    mem[1] = 32'hB000_000B;
    mem[2] = 32'hC000_000C;
    mem[3] = 32'hD000_000D;
    mem[32'h100 >> 2] = 32'hCAFE_0100;
    rst_n = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    m_pc = '0; m_ifpc = '0; m_instr = 32'h13; m_valid = 1'b0; m_cnt = '0;
    @(negedge clk);

    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("reset_instr", bus.if_id_instr, 32'h0000_0013);
    chk("reset_addr", {21'd0, bus.imem_addr}, 32'h0);

    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("run4_cnt", bus.fetch_cnt, 32'd4);
    chk("run4_instr", bus.if_id_instr, 32'hD000_000D);
    chk("run4_pc", bus.if_id_pc, 32'h0000_000C);

    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stall_addr", {21'd0, bus.imem_addr}, 32'h0000_0008);
      chk("stall_instr", bus.if_id_instr, 32'hB000_000B);
      chk("stall_pc", bus.if_id_pc, 32'h0000_0004);
      chk("stall_cnt", bus.fetch_cnt, 32'd2);
    end

    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre_redir_addr", {21'd0, bus.imem_addr}, 32'h0000_000C);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0103);
    chk("redir_addr", {21'd0, bus.imem_addr}, 32'h0000_0100);
    chk("redir_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("redir_instr", bus.if_id_instr, 32'h0000_0013);
    chk("redir_cnt", bus.fetch_cnt, 32'd3);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_redir_instr", bus.if_id_instr, 32'hCAFE_0100);
    chk("post_redir_valid", {31'd0, bus.if_id_valid}, 32'd1);

    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    chk("stall_redir_addr", {21'd0, bus.imem_addr}, 32'h0000_0200);
    chk("stall_redir_valid", {31'd0, bus.if_id_valid}, 32'd0);

    cycle(1'b1, 1'b0, 1'b1, 32'h0000_07FC);
    chk("wrap_addr0", {21'd0, bus.imem_addr}, 32'h0000_07FC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr1", {21'd0, bus.imem_addr}, 32'h0000_0000);
    chk("wrap_pc0", bus.if_id_pc, 32'h0000_07FC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc1", bus.if_id_pc, 32'h0000_0800);

    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0044);
    chk("midstall_rst_addr", {21'd0, bus.imem_addr}, 32'h0);
    chk("midstall_rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("midstall_rst_instr", bus.if_id_instr, 32'h0000_0013);
    chk("midstall_rst_cnt", bus.fetch_cnt, 32'd0);

    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
